// File: rtl/common.sv
// Shared types and default timing for the PS/2 host transmitter.
package common;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_REQ     = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_ACK     = 3'd4,
    ST_RELEASE = 3'd5
  } ps2tx_state_t;

  // Defaults assume a 28 MHz system clock.
  localparam int unsigned PS2TX_INHIBIT_CYCLES = 3360;    // 120 us
  localparam int unsigned PS2TX_START_TIMEOUT  = 420000;  // 15 ms
  localparam int unsigned PS2TX_PACKET_TIMEOUT = 56000;   // 2 ms

  // Frame after the start bit: 8 data bits, parity, stop.
  localparam int unsigned PS2TX_FRAME_BITS = 10;

  // Parity bit that makes the total count of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Pad conditioning for one PS/2 line: 2-flop synchronizer, 4-sample
// agreement filter (preset high) and a registered falling-edge strobe.
module ps2_line_filter (
  input  logic clk28,
  input  logic rst,
  input  logic pad_in,
  output logic filt,
  output logic fall
);

  logic       s1_q, s1_d;
  logic       s2_q, s2_d;
  logic       filt_q, filt_d;
  logic       fall_q, fall_d;
  logic [1:0] cnt_q, cnt_d;

  // Registers; the filter idles high so reset never looks like an edge.
  always_ff @(posedge clk28) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      filt_q <= filt_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  // Flip the output only on the 4th consecutive sample that disagrees with it.
  always_comb begin
    s1_d   = pad_in;
    s2_d   = s1_q;
    filt_d = filt_q;
    cnt_d  = 2'd0;
    if (s2_q != filt_q) begin
      if (cnt_q == 2'd3) begin
        filt_d = s2_q;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end
    fall_d = filt_q & ~filt_d;
  end

  assign filt = filt_q;
  assign fall = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, shift
// 8 data + odd parity + stop on device clock falls, then check the ACK.
module ps2_host_tx
  import common::*;
#(
  parameter int unsigned INHIBIT_CYCLES = PS2TX_INHIBIT_CYCLES,
  parameter int unsigned START_TIMEOUT  = PS2TX_START_TIMEOUT,
  parameter int unsigned PACKET_TIMEOUT = PS2TX_PACKET_TIMEOUT
) (
  input  logic       clk28,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned TMAX_A = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
  localparam int unsigned TMAX   = (TMAX_A > PACKET_TIMEOUT) ? TMAX_A : PACKET_TIMEOUT;
  localparam int unsigned TW     = $clog2(TMAX + 1);
  localparam int unsigned IW     = $clog2(PS2TX_FRAME_BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(PS2TX_FRAME_BITS - 1);

  ps2tx_state_t state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [PS2TX_FRAME_BITS-1:0] frame_q, frame_d;
  logic clk_oe_q, clk_oe_d;
  logic data_oe_q, data_oe_d;
  logic tx_ready_q, tx_ready_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic tmr_clr;

  logic fclk, fclk_fall, fdata, unused_data_fall;
  logic accept, pkt_to;

  ps2_line_filter u_clk_filt (
    .clk28  (clk28),
    .rst    (rst),
    .pad_in (ps2_clk_in),
    .filt   (fclk),
    .fall   (fclk_fall)
  );

  ps2_line_filter u_data_filt (
    .clk28  (clk28),
    .rst    (rst),
    .pad_in (ps2_data_in),
    .filt   (fdata),
    .fall   (unused_data_fall)
  );

  assign accept = tx_valid & tx_ready_q;
  assign pkt_to = ((state_q == ST_SHIFT) || (state_q == ST_ACK) || (state_q == ST_RELEASE)) &&
                  (tmr_q >= TW'(PACKET_TIMEOUT - 1));

  // State and registered outputs; reset releases both lines immediately.
  always_ff @(posedge clk28) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      idx_q      <= '0;
      frame_q    <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next-state: every abort path (timeouts, NACK) lands back in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_INHIBIT;
      ST_INHIBIT: if (tmr_q >= TW'(INHIBIT_CYCLES - 1)) state_d = ST_REQ;
      ST_REQ: begin
        if (fclk_fall) state_d = ST_SHIFT;
        else if (tmr_q >= TW'(START_TIMEOUT - 1)) state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        if (pkt_to) state_d = ST_IDLE;
        else if (fclk_fall && (idx_q == LAST_IDX)) state_d = ST_ACK;
      end
      ST_ACK: begin
        if (pkt_to) state_d = ST_IDLE;
        else if (fclk_fall) state_d = fdata ? ST_IDLE : ST_RELEASE;
      end
      ST_RELEASE: begin
        if (pkt_to || (fclk && fdata)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs and datapath, derived from the current/next state pair.
  always_comb begin
    frame_d = frame_q;
    if (accept) frame_d = {1'b1, odd_parity(tx_data), tx_data};

    idx_d = idx_q;
    if (state_q == ST_REQ) begin
      idx_d = '0;
    end else if ((state_q == ST_SHIFT) && fclk_fall && (idx_q != LAST_IDX)) begin
      idx_d = idx_q + IW'(1);
    end

    clk_oe_d  = (state_d == ST_INHIBIT);
    data_oe_d = 1'b0;
    if (state_d == ST_REQ) data_oe_d = 1'b1;
    else if (state_d == ST_SHIFT) data_oe_d = ~frame_q[idx_d];

    // One timer: inhibit count, start wait, then a packet timer spanning SHIFT..RELEASE.
    tmr_clr = (state_d == ST_IDLE) ||
              ((state_d != state_q) &&
               ((state_q == ST_IDLE) || (state_q == ST_INHIBIT) || (state_q == ST_REQ)));
    if (tmr_clr) tmr_d = '0;
    else if (tmr_q == TW'(TMAX)) tmr_d = tmr_q;
    else tmr_d = tmr_q + TW'(1);

    done_d     = (state_q == ST_RELEASE) && (state_d == ST_IDLE) && !pkt_to;
    err_d      = (state_q != ST_IDLE) && (state_d == ST_IDLE) && !done_d;
    busy_d     = (state_d != ST_IDLE);
    tx_ready_d = (state_q == ST_IDLE) && (state_d == ST_IDLE);
  end

  assign tx_ready    = tx_ready_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: directed bytes against an open-drain PS/2 device
// model, with a scoreboard consumed on every done/err pulse.
module tb_ps2_host_tx;

  localparam int unsigned INH  = 3360;
  localparam int unsigned STO  = 3000;
  localparam int unsigned PTO  = 2000;
  localparam int          HALF = 40;
  localparam int          LIM  = 12000;

  typedef struct {
    logic       is_err;
    logic       chk_bits;
    logic [9:0] bits;
    int         req_to;
  } exp_t;

  logic       clk28 = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       busy, done, err;

  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       glitch = 1'b0;
  logic [9:0] dev_bits = '0;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   inh_run = 0;
  int   inh_len = 0;
  int   req_start = 0;
  bit   err_pend = 1'b0;

  always #5 clk28 = ~clk28;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low) ^ glitch;
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .START_TIMEOUT  (STO),
    .PACKET_TIMEOUT (PTO)
  ) dut (
    .clk28       (clk28),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: measures inhibit length and REQ start, pops on each pulse.
  initial begin
    forever begin
      @(posedge clk28);
      #1;
      cyc++;
      if (err_pend) begin
        check("tx_ready_after_err", int'(tx_ready), 1);
        err_pend = 1'b0;
      end
      if (ps2_clk_oe) begin
        inh_run++;
      end else if (inh_run != 0) begin
        inh_len   = inh_run;
        inh_run   = 0;
        req_start = cyc;
      end
      if (done || err) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: done=%0d err=%0d with empty scoreboard", done, err);
        end else begin
          mon_e = exp_q.pop_front();
          check("done_pulse", int'(done), int'(!mon_e.is_err));
          check("err_pulse", int'(err), int'(mon_e.is_err));
          check("inhibit_len", inh_len, int'(INH));
          if (mon_e.chk_bits) check("frame_bits", int'(dev_bits), int'(mon_e.bits));
          if (mon_e.req_to >= 0) check("start_timeout_len", cyc - req_start, mon_e.req_to);
          if (err) begin
            check("oe_released_on_err", int'({ps2_clk_oe, ps2_data_oe}), 0);
            err_pend = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    while (!tx_ready && n < LIM) begin
      @(negedge clk28);
      n++;
    end
    check("ready_before_send", int'(tx_ready), 1);
    @(negedge clk28);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk28);
    #1;
    check("accepted_busy_inhibit", int'({busy, ps2_clk_oe, tx_ready}), 3'b110);
    @(negedge clk28);
    tx_valid = 1'b0;
  endtask

  // Device model: clocks 12 pulses, samples data on each rising edge,
  // drives ACK low across pulses 11-12 when ack is set.
  task automatic dev_run(input bit ack, input bit gl, input int stop_after);
    int n;
    n = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1 && busy) && n < LIM) begin
      @(negedge clk28);
      n++;
    end
    check("request_to_send_seen", int'(n < LIM), 1);
    repeat (20) @(negedge clk28);
    for (int p = 1; p <= 12; p++) begin
      dev_clk_low = 1'b1;
      if (p == 11 && ack) dev_data_low = 1'b1;
      for (int c = 0; c < HALF; c++) begin
        @(negedge clk28);
        if (p == stop_after && c == 12) return;
        glitch = gl && (c == HALF / 2) && (p >= 2) && (p <= 9);
      end
      glitch = 1'b0;
      if (p <= 10) dev_bits[p-1] = ps2_data_in;
      dev_clk_low = 1'b0;
      for (int c = 0; c < HALF; c++) begin
        @(negedge clk28);
        glitch = gl && (c == HALF / 2) && (p >= 2) && (p <= 9);
      end
      glitch = 1'b0;
    end
    dev_data_low = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < LIM) begin
      @(negedge clk28);
      n++;
    end
    check("returned_idle", int'(busy), 0);
    repeat (5) @(negedge clk28);
  endtask

  task automatic xact(input logic [7:0] d, input logic par, input bit ack, input bit gl, input bit poke);
    exp_t e;
    e.is_err   = !ack;
    e.chk_bits = 1'b1;
    e.bits     = {1'b1, par, d};
    e.req_to   = -1;
    dev_bits   = '0;
    exp_q.push_back(e);
    send(d);
    if (poke) begin
      // A second request while busy must be dropped without relatching.
      @(negedge clk28);
      tx_data  = 8'hAA;
      tx_valid = 1'b1;
      repeat (10) @(negedge clk28);
      tx_valid = 1'b0;
    end
    dev_run(ack, gl, 0);
    wait_idle();
  endtask

  initial begin
    exp_t e;
    rst      = 1'b1;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    repeat (4) @(posedge clk28);
    #1;
    check("reset_outputs", int'({tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, err}), 0);
    @(negedge clk28);
    rst = 1'b0;
    @(posedge clk28);
    #1;
    check("ready_after_reset", int'(tx_ready), 1);

    // 0xED: ones=6 -> parity 1
    xact(8'hED, 1'b1, 1'b1, 1'b0, 1'b0);
    // 0x01: ones=1 -> parity 0, plus a dropped request while busy
    xact(8'h01, 1'b0, 1'b1, 1'b0, 1'b1);
    // 0xFF: ones=8 -> parity 1
    xact(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);

    // Silent device: start timeout
    e.is_err   = 1'b1;
    e.chk_bits = 1'b0;
    e.bits     = '0;
    e.req_to   = int'(STO);
    exp_q.push_back(e);
    send(8'h55);
    wait_idle();

    // 0x5A: ones=4 -> parity 1, device never ACKs
    xact(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset while shifting bit 4 of 0xE3 (bit4=0, so data is being pulled low)
    send(8'hE3);
    dev_run(1'b0, 1'b0, 5);
    check("mid_shift_data_driven", int'({busy, ps2_data_oe}), 2'b11);
    rst = 1'b1;
    dev_clk_low = 1'b0;
    @(posedge clk28);
    #1;
    check("reset_mid_shift_outputs", int'({ps2_clk_oe, ps2_data_oe, done, err, busy}), 0);
    @(negedge clk28);
    rst = 1'b0;
    @(posedge clk28);
    #1;
    check("ready_after_mid_reset", int'(tx_ready), 1);
    repeat (5) @(negedge clk28);

    // 0xF4: ones=5 -> parity 0
    xact(8'hF4, 1'b0, 1'b1, 1'b0, 1'b0);
    // 0x96: ones=4 -> parity 1, single-cycle glitches on the clock line
    xact(8'h96, 1'b1, 1'b1, 1'b1, 1'b0);

    repeat (20) @(negedge clk28);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
